// File: rtl/mult_seq_controller.sv
// Sequential WIDTH x WIDTH unsigned multiplier built around one 4x4 array multiplier.
// Visits every nibble pair (j inner, i outer) and accumulates the shifted partial products.
module mult_seq_controller #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    generate
        if (WIDTH < 4 || WIDTH > 16 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("mult_seq_controller: WIDTH must be a multiple of 4 in 4..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_lat_q, a_lat_d;
    logic [WIDTH-1:0]     b_lat_q, b_lat_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [IDX_W-1:0]     i_q, i_d;
    logic [IDX_W-1:0]     j_q, j_d;

    logic [3:0]           a_nib, b_nib;
    logic [7:0]           pp;
    logic [IDX_W:0]       sum_ij;
    logic [2*WIDTH-1:0]   pp_ext;
    logic [2*WIDTH-1:0]   pp_shift;
    logic [2*WIDTH-1:0]   acc_sum;

    // Combinational 4x4 array multiplier: AND rows summed with their bit weight.
    function automatic logic [7:0] mul4x4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            if (y[k]) s = s + ({4'b0000, x} << k);
        end
        return s;
    endfunction

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int n = 0; n < NIB; n++) begin
            if (i_q == IDX_W'(n)) a_nib = a_lat_q[4*n +: 4];
            if (j_q == IDX_W'(n)) b_nib = b_lat_q[4*n +: 4];
        end
    end

    assign pp       = mul4x4(a_nib, b_nib);
    assign sum_ij   = {1'b0, i_q} + {1'b0, j_q};
    always_comb begin
        pp_ext      = '0;
        pp_ext[7:0] = pp;
    end
    assign pp_shift = pp_ext << {sum_ij, 2'b00};
    assign acc_sum  = acc_q + pp_shift;

    always_comb begin
        state_d = state_q;
        a_lat_d = a_lat_q;
        b_lat_d = b_lat_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_lat_d = a;
                    b_lat_d = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = acc_sum;
                if (i_q == LAST_IDX && j_q == LAST_IDX) begin
                    // product only updates here, so it never shows a partial sum
                    prod_d  = acc_sum;
                    state_d = S_DONE;
                end else if (j_q == LAST_IDX) begin
                    j_d = '0;
                    i_d = i_q + 1'b1;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_lat_q <= '0;
            b_lat_q <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_lat_q <= a_lat_d;
            b_lat_q <= b_lat_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_CALC) || (state_q == S_DONE);
    assign product   = prod_q;

endmodule

// File: tb/tb_mult_seq_controller.sv
// Bench for mult_seq_controller at WIDTH 8, 16 and 4: vector table, hand-built corner
// sequences and random operands checked against plain integer multiplication.
module tb_mult_seq_controller;

    logic        clk;
    logic        rst_n;
    logic [15:0] a_bus, b_bus;
    logic        iv8, iv16, iv4;
    logic        or8, or16, or4;
    logic        ir8, ir16, ir4;
    logic        ov8, ov16, ov4;
    logic        bz8, bz16, bz4;
    logic [15:0] p8;
    logic [31:0] p16;
    logic [7:0]  p4;

    int total = 0;
    int bad   = 0;

    int          cur_w;
    logic        cur_ir, cur_ov, cur_busy;
    logic [31:0] cur_prod;

    typedef struct {
        int          w;
        logic [15:0] a;
        logic [15:0] b;
        int          stall;
        logic [31:0] expv;
    } vec_t;

    vec_t vecs[7];

    mult_seq_controller #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .out_valid(ov8), .out_ready(or8),
        .product(p8), .busy(bz8)
    );

    mult_seq_controller #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a_bus), .b(b_bus), .out_valid(ov16), .out_ready(or16),
        .product(p16), .busy(bz16)
    );

    mult_seq_controller #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a_bus[3:0]), .b(b_bus[3:0]), .out_valid(ov4), .out_ready(or4),
        .product(p4), .busy(bz4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cur_ir   = ir8;
        cur_ov   = ov8;
        cur_busy = bz8;
        cur_prod = {16'h0, p8};
        if (cur_w == 16) begin
            cur_ir   = ir16;
            cur_ov   = ov16;
            cur_busy = bz16;
            cur_prod = p16;
        end else if (cur_w == 4) begin
            cur_ir   = ir4;
            cur_ov   = ov4;
            cur_busy = bz4;
            cur_prod = {24'h0, p4};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endtask

    task automatic set_iv(input int w, input logic v);
        iv8  = (w == 8)  ? v : 1'b0;
        iv16 = (w == 16) ? v : 1'b0;
        iv4  = (w == 4)  ? v : 1'b0;
    endtask

    task automatic set_or(input int w, input logic v);
        or8  = (w == 8)  ? v : 1'b0;
        or16 = (w == 16) ? v : 1'b0;
        or4  = (w == 4)  ? v : 1'b0;
    endtask

    // One full transaction; called just after a rising edge with the DUT in IDLE.
    task automatic run_txn(input int w, input logic [15:0] av, input logic [15:0] bv,
                           input int stall, input logic [31:0] expv);
        int lat;
        int edges;
        lat   = (w / 4) * (w / 4);
        cur_w = w;
        #0;
        chk("idle_in_ready", 32'(cur_ir), 32'd1);
        a_bus = av;
        b_bus = bv;
        set_iv(w, 1'b1);
        set_or(w, 1'b0);
        @(posedge clk); #1;
        // operands change and in_valid stays high: both must be ignored now
        a_bus = 16'hFFFF;
        b_bus = 16'hFFFF;
        chk("busy_in_ready", 32'(cur_ir), 32'd0);
        chk("busy_flag", 32'(cur_busy), 32'd1);
        edges = 0;
        while (!cur_ov && edges < 64) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("latency", 32'(edges), 32'(lat));
        chk("product", cur_prod, expv);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(cur_ov), 32'd1);
            chk("hold_product", cur_prod, expv);
        end
        set_iv(w, 1'b0);
        set_or(w, 1'b1);
        @(posedge clk); #1;
        set_or(w, 1'b0);
        chk("hs_valid", 32'(cur_ov), 32'd0);
        chk("hs_in_ready", 32'(cur_ir), 32'd1);
        chk("hs_busy", 32'(cur_busy), 32'd0);
        chk("retain_product", cur_prod, expv);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        logic [31:0] rexp;
        int          rw;

        vecs[0] = '{w: 8,  a: 16'h00FF, b: 16'h00FF, stall: 0, expv: 32'h0000FE01};
        vecs[1] = '{w: 8,  a: 16'h0000, b: 16'h00A5, stall: 0, expv: 32'h00000000};
        vecs[2] = '{w: 8,  a: 16'h0001, b: 16'h00A5, stall: 0, expv: 32'h000000A5};
        vecs[3] = '{w: 8,  a: 16'h0037, b: 16'h004C, stall: 5, expv: 32'h00001054};
        vecs[4] = '{w: 8,  a: 16'h0012, b: 16'h0034, stall: 1, expv: 32'h000003A8};
        vecs[5] = '{w: 16, a: 16'hFFFF, b: 16'hFFFF, stall: 2, expv: 32'hFFFE0001};
        vecs[6] = '{w: 4,  a: 16'h000F, b: 16'h000F, stall: 3, expv: 32'h000000E1};

        cur_w = 8;
        rst_n = 1'b0;
        a_bus = '0;
        b_bus = '0;
        set_iv(0, 1'b0);
        set_or(0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready8", 32'(ir8), 32'd1);
        chk("rst_out_valid8", 32'(ov8), 32'd0);
        chk("rst_busy8", 32'(bz8), 32'd0);
        chk("rst_product8", {16'h0, p8}, 32'h0);
        chk("rst_in_ready16", 32'(ir16), 32'd1);
        chk("rst_product16", p16, 32'h0);
        chk("rst_in_ready4", 32'(ir4), 32'd1);
        chk("rst_product4", {24'h0, p4}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < 7; n++) begin
            run_txn(vecs[n].w, vecs[n].a, vecs[n].b, vecs[n].stall, vecs[n].expv);
        end

        // Abort mid-computation: reset in the second CALC cycle.
        cur_w = 8;
        a_bus = 16'h0055;
        b_bus = 16'h0066;
        set_iv(8, 1'b1);
        @(posedge clk); #1;
        set_iv(8, 1'b0);
        @(posedge clk); #1;
        chk("pre_abort_busy", 32'(bz8), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(ov8), 32'd0);
        chk("abort_in_ready", 32'(ir8), 32'd1);
        chk("abort_busy", 32'(bz8), 32'd0);
        chk("abort_product", {16'h0, p8}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(8, 16'h000F, 16'h000F, 0, 32'h000000E1);

        // Random operands against integer multiplication.
        for (int n = 0; n < 30; n++) begin
            case (n % 3)
                0:       rw = 16;
                1:       rw = 8;
                default: rw = 4;
            endcase
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (rw == 8) begin
                ra = ra & 16'h00FF;
                rb = rb & 16'h00FF;
            end else if (rw == 4) begin
                ra = ra & 16'h000F;
                rb = rb & 16'h000F;
            end
            rexp = 32'(ra) * 32'(rb);
            run_txn(rw, ra, rb, int'($urandom_range(0, 3)), rexp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
